mips_fetch_unit: RTL

Parametrised instruction-fetch front end for the next-generation MIPS core. It replaces the single-cycle PC register and PC+4 path with a decoupled fetch stage. The block owns the PC and issues word reads to a 1-cycle-latency program memory. Fetched words land in a FIFO and go to decode over a valid/ready handshake. Later stages redirect the PC on branch, jump, JR or exception, which flushes all speculative state.

---
 rtl/mips_fetch_unit_pkg.sv | 29 ++
 rtl/mips_fetch_unit_if.sv | 46 ++++
 rtl/mips_fetch_unit_fifo.sv | 74 +++++++
 rtl/mips_fetch_unit.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/mips_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// mips_fetch_pkg
// Shared definitions for the MIPS instruction-fetch front end.
//   OPCODE_J / OPCODE_JAL : primary opcodes recognised by jump predecode
//   PC_STEP               : byte distance between sequential instructions
//   fetch_entry           : one fetch-buffer entry {data, pc, jumped} at the
//                           default 32-bit data / 32-bit address widths
//   isJumpOpcode()        : true for J and JAL
// -----------------------------------------------------------------------------
package mips_fetch_pkg;

   localparam logic [5:0] OPCODE_J   = 6'b000010;
   localparam logic [5:0] OPCODE_JAL = 6'b000011;
   localparam int         PC_STEP    = 4;

   localparam int FETCH_ADDR_WIDTH = 32;
   localparam int FETCH_DATA_WIDTH = 32;

   typedef struct packed {
      logic [FETCH_DATA_WIDTH-1:0] data;
      logic [FETCH_ADDR_WIDTH-1:0] pc;
      logic                        jumped;
   } fetch_entry;

   function automatic logic isJumpOpcode(input logic [5:0] opcode);
      return (opcode == OPCODE_J) || (opcode == OPCODE_JAL);
   endfunction

endpackage

// File: rtl/mips_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// mips_fetch_if
// Bundles the program-memory port, the redirect request and the decode-side
// valid/ready handshake of the fetch unit.
//   master : the fetch unit (drives imem_addr/imem_rd and all inst_* outputs)
//   slave  : the environment (memory, redirecting stages, decode)
// Signals:
//   imem_addr, imem_rd, imem_data      program memory, 1-cycle read latency
//   redirect_valid, redirect_pc        PC redirect from a later stage
//   inst_valid, inst_ready             decode handshake
//   inst_data, inst_pc, inst_pc4       head instruction, its PC and PC+4
//   inst_jumped                        head entry already redirected by predecode
//   fifo_count                         fetch buffer occupancy
// -----------------------------------------------------------------------------
interface mips_fetch_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4
);
   localparam int COUNT_WIDTH = $clog2(FIFO_DEPTH + 1);

   logic [ADDR_WIDTH-1:0]  imem_addr;
   logic                   imem_rd;
   logic [DATA_WIDTH-1:0]  imem_data;
   logic                   redirect_valid;
   logic [ADDR_WIDTH-1:0]  redirect_pc;
   logic                   inst_valid;
   logic                   inst_ready;
   logic [DATA_WIDTH-1:0]  inst_data;
   logic [ADDR_WIDTH-1:0]  inst_pc;
   logic [ADDR_WIDTH-1:0]  inst_pc4;
   logic                   inst_jumped;
   logic [COUNT_WIDTH-1:0] fifo_count;

   modport master (
      output imem_addr, imem_rd, inst_valid, inst_data, inst_pc, inst_pc4,
             inst_jumped, fifo_count,
      input  imem_data, redirect_valid, redirect_pc, inst_ready
   );

   modport slave (
      input  imem_addr, imem_rd, inst_valid, inst_data, inst_pc, inst_pc4,
             inst_jumped, fifo_count,
      output imem_data, redirect_valid, redirect_pc, inst_ready
   );
endinterface

// File: rtl/mips_fetch_unit_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO holding fetched instructions. The head entry is read from
// storage registers, so it is stable while no pop occurs.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   flush           synchronous clear; wins over push and pop
//   push, pushData  write an entry (caller guarantees there is room)
//   pop             consume the head entry (ignored when empty)
//   headData        head entry
//   headValid       FIFO not empty
//   count           current occupancy
// -----------------------------------------------------------------------------
module fetch_fifo #(
   parameter  int WIDTH       = 65,
   parameter  int DEPTH       = 4,
   localparam int PTR_WIDTH   = $clog2(DEPTH),
   localparam int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   push,
   input  logic [WIDTH-1:0]       pushData,
   input  logic                   pop,
   output logic [WIDTH-1:0]       headData,
   output logic                   headValid,
   output logic [COUNT_WIDTH-1:0] count
);

   logic [WIDTH-1:0]       mem [DEPTH];
   logic [PTR_WIDTH-1:0]   wrPtrReg;
   logic [PTR_WIDTH-1:0]   rdPtrReg;
   logic [COUNT_WIDTH-1:0] countReg;
   logic                   doPush;
   logic                   doPop;

   assign headValid = (countReg != '0);
   assign doPush    = push && !flush;
   assign doPop     = pop && headValid;

   // Storage is never reset: an entry is only visible once countReg covers it.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : gEntry
      always_ff @(posedge clk) begin
         if (doPush && (wrPtrReg == PTR_WIDTH'(gi))) begin
            mem[gi] <= pushData;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wrPtrReg <= '0;
         rdPtrReg <= '0;
         countReg <= '0;
      end else if (flush) begin
         wrPtrReg <= '0;
         rdPtrReg <= '0;
         countReg <= '0;
      end else begin
         if (doPush) wrPtrReg <= wrPtrReg + PTR_WIDTH'(1);
         if (doPop)  rdPtrReg <= rdPtrReg + PTR_WIDTH'(1);
         case ({doPush, doPop})
            2'b10:   countReg <= countReg + COUNT_WIDTH'(1);
            2'b01:   countReg <= countReg - COUNT_WIDTH'(1);
            default: countReg <= countReg;
         endcase
      end
   end

   assign headData = mem[rdPtrReg];
   assign count    = countReg;

endmodule

// File: rtl/mips_fetch_unit.sv
// -----------------------------------------------------------------------------
// mips_fetch_unit
// Decoupled instruction-fetch stage. Owns the PC, issues word reads to a
// 1-cycle-latency program memory, buffers returned words in fetch_fifo and
// hands them to decode over a valid/ready handshake. A redirect from a later
// stage reloads the PC and discards every speculative fetch.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    mips_fetch_if.master (memory port, redirect, decode handshake,
//          fifo_count)
// Optional build macro FETCH_JUMP_PREDECODE_EN: J/JAL words are recognised as
// they return from memory and the PC is steered to the jump target at once;
// such entries are flagged with inst_jumped. Without the macro, J/JAL are
// ordinary words and inst_jumped is tied to 0.
// -----------------------------------------------------------------------------
module mips_fetch_unit
   import mips_fetch_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    FIFO_DEPTH = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(32'h0040_0000)
) (
   input logic        clk,
   input logic        reset,
   mips_fetch_if.master bus
);

   localparam int                    COUNT_WIDTH = $clog2(FIFO_DEPTH + 1);
   localparam int                    ENTRY_WIDTH = DATA_WIDTH + ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH-1:0] STEP        = ADDR_WIDTH'(PC_STEP);

   // Same layout as fetch_entry, sized by this instance's parameters.
   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [ADDR_WIDTH-1:0] pc;
      logic                  jumped;
   } entryT;

   logic [ADDR_WIDTH-1:0]  pcReg;
   logic [ADDR_WIDTH-1:0]  pcNext;
   logic [ADDR_WIDTH-1:0]  inflightPcReg;
   logic                   inflightReg;
   logic                   killReg;
   logic [COUNT_WIDTH-1:0] fifoCount;
   logic [COUNT_WIDTH:0]   occupancy;
   logic                   credit;
   logic                   flush;
   logic                   issue;
   logic                   returnValid;
   logic                   jumpTaken;
   logic                   headValid;
   logic                   popReq;
   entryT                  pushEntry;
   entryT                  headEntry;
   logic                   unusedRedirectBits;

   assign flush       = bus.redirect_valid;
   assign returnValid = inflightReg && !killReg;

   // Credit uses registered occupancy only: a slot freed by a pop this cycle
   // is not reusable until next cycle, so the FIFO can never overflow.
   assign occupancy = {1'b0, fifoCount} + (COUNT_WIDTH+1)'(inflightReg);
   assign credit    = occupancy < (COUNT_WIDTH+1)'(FIFO_DEPTH);

   // reset also gates the strobe so no read is requested while held in reset.
   assign issue = reset && !flush && !jumpTaken && credit;

`ifdef FETCH_JUMP_PREDECODE_EN
   logic [ADDR_WIDTH-1:0] returnPc4;
   logic [ADDR_WIDTH-1:0] jumpTarget;
   logic                  unusedPc4Bits;

   // J/JAL target: region bits of the delay-slot-free PC+4, 26-bit index.
   assign returnPc4     = inflightPcReg + STEP;
   assign jumpTarget    = {returnPc4[ADDR_WIDTH-1:28], bus.imem_data[25:0], 2'b00};
   assign unusedPc4Bits = ^returnPc4[27:0];
   // An external redirect in the same cycle overrides predecode.
   assign jumpTaken     = returnValid && !flush &&
                          isJumpOpcode(bus.imem_data[DATA_WIDTH-1 -: 6]);
`else
   assign jumpTaken = 1'b0;
`endif

   always_comb begin
      pcNext = pcReg;
      if (issue) pcNext = pcReg + STEP;
`ifdef FETCH_JUMP_PREDECODE_EN
      if (jumpTaken) pcNext = jumpTarget;
`endif
      if (flush) pcNext = {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};
   end

   assign unusedRedirectBits = ^bus.redirect_pc[1:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pcReg         <= RESET_PC;
         inflightReg   <= 1'b0;
         inflightPcReg <= RESET_PC;
         killReg       <= 1'b0;
      end else begin
         pcReg       <= pcNext;
         inflightReg <= issue;
         if (issue) inflightPcReg <= pcReg;
         // Marks a read launched alongside a flush so its data is dropped.
         // Issue is already held off by redirect and predecode, so with the
         // single-cycle memory the returning word in a flush cycle is
         // discarded by the FIFO flush itself.
         killReg <= issue && (flush || jumpTaken);
      end
   end

   assign pushEntry.data   = bus.imem_data;
   assign pushEntry.pc     = inflightPcReg;
   assign pushEntry.jumped = jumpTaken;

   assign popReq = headValid && bus.inst_ready;

   fetch_fifo #(
      .WIDTH (ENTRY_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) fifo (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .push     (returnValid),
      .pushData (pushEntry),
      .pop      (popReq),
      .headData (headEntry),
      .headValid(headValid),
      .count    (fifoCount)
   );

   assign bus.imem_addr  = pcReg;
   assign bus.imem_rd    = issue;
   assign bus.inst_valid = headValid;
   assign bus.inst_data  = headEntry.data;
   assign bus.inst_pc    = headEntry.pc;
   assign bus.inst_pc4   = headEntry.pc + STEP;
   assign bus.fifo_count = fifoCount;

`ifdef FETCH_JUMP_PREDECODE_EN
   assign bus.inst_jumped = headValid && headEntry.jumped;
`else
   logic unusedJumped;
   assign unusedJumped    = headEntry.jumped;
   assign bus.inst_jumped = 1'b0;
`endif

endmodule
